// File: rtl/gcd_operand_loader_if.sv
// rtl/gcd_operand_loader_if.sv - word-serial command/result streams of the GCD operand loader
//
// Purpose: bundles the inbound command/operand stream and the outbound
// header/result stream into one interface.
// Ports (signals):
//   in_valid  / in_ready  / in_data   inbound words, host -> loader
//   out_valid / out_ready / out_data  outbound words, loader -> host
// Modports:
//   slave  - loader side
//   master - host side
interface gcd_operand_loader_if #(
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gcd_operand_loader.sv
// rtl/gcd_operand_loader.sv - word-serial front end that loads GCD operands and drains results
//
// Purpose: takes a command word plus operands A and B as LSW-first word
// streams, presents them to the GCD core with a one-cycle start pulse, waits
// for done (or a timeout) and streams out a header plus both Bezout
// coefficients. One job in flight at a time.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s                 stream interface (in_* command/operands, out_* results)
//   busy              high whenever not IDLE
//   core_start        one-cycle start pulse to the core
//   core_op_code      latched op code (command bits 2:0)
//   core_const_time   latched constant-time flag (command bit 3)
//   core_a, core_b    assembled operands
//   core_done         core completion
//   core_cycle_count  core cycle count, captured with done
//   core_bezout_a/b   Bezout coefficients, captured with done
module gcd_operand_loader #(
  parameter int WORD_W  = 32,
  parameter int OPND_W  = 1279,
  parameter int RES_W   = 1284,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  gcd_operand_loader_if.slave s,
  output logic                busy,
  output logic                core_start,
  output logic [2:0]          core_op_code,
  output logic                core_const_time,
  output logic [OPND_W-1:0]   core_a,
  output logic [OPND_W-1:0]   core_b,
  input  logic                core_done,
  input  logic [11:0]         core_cycle_count,
  input  logic [RES_W-1:0]    core_bezout_a,
  input  logic [RES_W-1:0]    core_bezout_b
);
  localparam int OPND_WORDS  = (OPND_W + WORD_W - 1) / WORD_W;
  localparam int RES_WORDS   = (RES_W + WORD_W - 1) / WORD_W;
  localparam int DRAIN_WORDS = 1 + 2 * RES_WORDS;
  localparam int LAST_OP     = OPND_WORDS - 1;
  localparam int LAST_RES    = RES_WORDS - 1;
  localparam int OP_TOP      = OPND_W - LAST_OP * WORD_W;   // valid bits in last operand word
  localparam int RES_TOP     = RES_W - LAST_RES * WORD_W;   // valid bits in last result word
  localparam int IDX_W       = $clog2(DRAIN_WORDS);
  localparam int CNT_W       = $clog2(TIMEOUT);
  localparam int OP_SEL_W    = $clog2(OPND_W);
  localparam int RES_SEL_W   = $clog2(RES_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               ct_q, ct_d;
  logic [OPND_W-1:0]  a_q, a_d, b_q, b_d;
  logic               status_q, status_d;
  logic [11:0]        cyc_q, cyc_d;
  logic [RES_W-1:0]   bza_q, bza_d, bzb_q, bzb_d;

  logic [OP_SEL_W-1:0]  op_base;
  logic [IDX_W-1:0]     coef_idx;
  logic [RES_SEL_W-1:0] res_base;
  logic [RES_W-1:0]     coef;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      ct_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      status_q <= 1'b0;
      cyc_q    <= '0;
      bza_q    <= '0;
      bzb_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ct_q     <= ct_d;
      a_q      <= a_d;
      b_q      <= b_d;
      status_q <= status_d;
      cyc_q    <= cyc_d;
      bza_q    <= bza_d;
      bzb_q    <= bzb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ct_d     = ct_q;
    a_d      = a_q;
    b_d      = b_q;
    status_d = status_q;
    cyc_d    = cyc_q;
    bza_d    = bza_q;
    bzb_d    = bzb_q;
    op_base  = OP_SEL_W'(idx_q) * OP_SEL_W'(WORD_W);

    case (state_q)
      S_IDLE: begin
        if (s.in_valid) begin
          op_d    = s.in_data[2:0];
          ct_d    = s.in_data[3];
          a_d     = '0;
          b_d     = '0;
          idx_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (s.in_valid) begin
          // The last word only partly fits; its surplus top bit(s) are dropped.
          if (idx_q == IDX_W'(LAST_OP)) begin
            if (state_q == S_LOAD_A) a_d[OPND_W-1 -: OP_TOP] = s.in_data[OP_TOP-1:0];
            else                     b_d[OPND_W-1 -: OP_TOP] = s.in_data[OP_TOP-1:0];
            idx_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
          end else begin
            if (state_q == S_LOAD_A) a_d[op_base +: WORD_W] = s.in_data;
            else                     b_d[op_base +: WORD_W] = s.in_data;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_START: begin
        // core_done is deliberately not looked at here.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          status_d = 1'b0;
          cyc_d    = core_cycle_count;
          bza_d    = core_bezout_a;
          bzb_d    = core_bezout_b;
          idx_d    = '0;
          state_d  = S_DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          status_d = 1'b1;
          cyc_d    = '0;
          bza_d    = '0;
          bzb_d    = '0;
          idx_d    = '0;
          state_d  = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (s.out_ready) begin
          if (idx_q == IDX_W'(DRAIN_WORDS - 1)) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drain word mux: 0 = header, 1..RES_WORDS = bezout_a, rest = bezout_b.
  always_comb begin
    coef_idx   = '0;
    coef       = bza_q;
    res_base   = '0;
    s.out_data = '0;
    if (idx_q > IDX_W'(RES_WORDS)) begin
      coef_idx = idx_q - IDX_W'(RES_WORDS + 1);
      coef     = bzb_q;
    end else if (idx_q != '0) begin
      coef_idx = idx_q - IDX_W'(1);
    end
    res_base = RES_SEL_W'(coef_idx) * RES_SEL_W'(WORD_W);
    if (state_q == S_DRAIN) begin
      if (idx_q == '0)
        s.out_data = {status_q, {(WORD_W - 13){1'b0}}, cyc_q};
      else if (coef_idx == IDX_W'(LAST_RES))
        s.out_data = {{(WORD_W - RES_TOP){1'b0}}, coef[RES_W-1 -: RES_TOP]};
      else
        s.out_data = coef[res_base +: WORD_W];
    end
  end

  // in_ready is forced low while reset is held so every output reads 0 then.
  assign s.in_ready = !rst && (state_q == S_IDLE || state_q == S_LOAD_A || state_q == S_LOAD_B);
  assign s.out_valid      = (state_q == S_DRAIN);
  assign busy             = (state_q != S_IDLE);
  assign core_start       = (state_q == S_START);
  assign core_op_code     = op_q;
  assign core_const_time  = ct_q;
  assign core_a           = a_q;
  assign core_b           = b_q;
endmodule

// File: tb/tb_gcd_operand_loader.sv
// tb/tb_gcd_operand_loader.sv - self-checking bench for gcd_operand_loader
module tb_gcd_operand_loader;
  localparam int M_NORMAL  = 0;
  localparam int M_HOLD    = 1;
  localparam int M_TIMEOUT = 2;

  typedef struct {
    logic [2:0]    op;
    logic          ct;
    logic [1278:0] a;
    logic [1278:0] b;
    logic [11:0]   cyc;
    logic [1283:0] bza;
    logic [1283:0] bzb;
    int            mode;
    bit            gaps;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy, core_start, core_const_time, core_done;
  logic [2:0]    core_op_code;
  logic [1278:0] core_a, core_b;
  logic [11:0]   core_cycle_count;
  logic [1283:0] core_bezout_a, core_bezout_b;

  int   pass_cnt  = 0;
  int   check_cnt = 0;
  int   start_cnt = 0;
  vec_t vecs[4];

  gcd_operand_loader_if #(.WORD_W(32)) ifc ();

  gcd_operand_loader dut (
    .clk              (clk),
    .rst              (rst),
    .s                (ifc),
    .busy             (busy),
    .core_start       (core_start),
    .core_op_code     (core_op_code),
    .core_const_time  (core_const_time),
    .core_a           (core_a),
    .core_b           (core_b),
    .core_done        (core_done),
    .core_cycle_count (core_cycle_count),
    .core_bezout_a    (core_bezout_a),
    .core_bezout_b    (core_bezout_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [1283:0] act, input logic [1283:0] exp);
    logic [1283:0] x, y;
    check_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      for (int k = 0; k < 41; k++) begin
        x = act >> (k * 32);
        y = exp >> (k * 32);
        if (x[31:0] !== y[31:0]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, k, x[31:0], y[31:0]);
          break;
        end
      end
    end
  endtask

  function automatic logic [1283:0] rnd_wide();
    logic [1311:0] r;
    for (int i = 0; i < 41; i++) r = {r[1279:0], $urandom()};
    return r[1283:0];
  endfunction

  function automatic logic [31:0] exp_word(input vec_t v, input int k);
    logic [1311:0] pad;
    int            w;
    if (k == 0) return (v.mode == M_TIMEOUT) ? 32'h8000_0000 : {20'h0, v.cyc};
    if (v.mode == M_TIMEOUT) return 32'h0;
    pad = (k <= 41) ? {28'h0, v.bza} : {28'h0, v.bzb};
    w   = (k <= 41) ? k - 1 : k - 42;
    pad = pad >> (w * 32);
    return pad[31:0];
  endfunction

  // Entered and left on a negedge; the word is taken at the posedge in between.
  task automatic send_word(input logic [31:0] w, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin ifc.in_valid = 1'b0; @(negedge clk); end
    end
    ifc.in_valid = 1'b1;
    ifc.in_data  = w;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (ifc.in_ready !== 1'b1) chk("in_ready_timeout", {63'h0, ifc.in_ready}, 64'h1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_operand(input logic [1278:0] x, input bit gaps);
    logic [1279:0] p;
    p = {gaps, x};  // with gaps, word 39 carries a stray bit 31 that must be dropped
    for (int k = 0; k < 40; k++) begin
      send_word(p[31:0], gaps);
      p = p >> 32;
    end
  endtask

  task automatic respond_core(input vec_t v);
    int n;
    case (v.mode)
      M_NORMAL: begin
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        core_done = 1'b1; core_cycle_count = v.cyc;
        core_bezout_a = v.bza; core_bezout_b = v.bzb;
        @(negedge clk);
        core_done = 1'b0; core_cycle_count = ~v.cyc;
        core_bezout_a = ~v.bza; core_bezout_b = ~v.bzb;
      end
      M_HOLD: begin
        core_done = 1'b1; core_cycle_count = 12'hBAD;
        core_bezout_a = ~v.bza; core_bezout_b = ~v.bzb;
        @(negedge clk);
        chk("hold_done_ignored_in_start", {62'h0, busy, ifc.out_valid}, 64'h2);
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        core_done = 1'b1; core_cycle_count = v.cyc;
        core_bezout_a = v.bza; core_bezout_b = v.bzb;
        @(negedge clk);
        core_done = 1'b0; core_cycle_count = 12'h0;
        core_bezout_a = '0; core_bezout_b = '0;
      end
      default: begin
        core_done = 1'b0;
        n = 0;
        while (ifc.out_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        chk("timeout_latency", 64'(n), 64'd4097);
      end
    endcase
  endtask

  task automatic drain(input vec_t v);
    int          n;
    logic [31:0] d0;
    n = 0;
    while (ifc.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("out_valid_rises", {63'h0, ifc.out_valid}, 64'h1);
    for (int k = 0; k < 83; k++) begin
      if (v.gaps) begin
        ifc.out_ready = 1'b0;
        d0 = ifc.out_data;
        n  = $urandom_range(0, 2);
        if (n > 0) begin
          repeat (n) @(negedge clk);
          chk($sformatf("stall_stable_w%0d", k), {31'h0, ifc.out_valid, ifc.out_data}, {31'h0, 1'b1, d0});
        end
      end
      chk($sformatf("drain_w%0d", k), {32'h0, ifc.out_data}, {32'h0, exp_word(v, k)});
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
    end
    chk("idle_after_drain", {62'h0, busy, ifc.out_valid}, 64'h0);
  endtask

  task automatic run_job(input int vi);
    vec_t v;
    int   s0;
    v  = vecs[vi];
    s0 = start_cnt;
    send_word({28'hABCDEF1, v.ct, v.op}, v.gaps);
    send_operand(v.a, v.gaps);
    send_operand(v.b, v.gaps);
    chk($sformatf("j%0d_start_state", vi), {61'h0, core_start, ifc.in_ready, busy}, 64'h5);
    chk_w($sformatf("j%0d_core_a", vi), {5'h0, core_a}, {5'h0, v.a});
    chk_w($sformatf("j%0d_core_b", vi), {5'h0, core_b}, {5'h0, v.b});
    chk($sformatf("j%0d_op_ct", vi), {60'h0, core_const_time, core_op_code}, {60'h0, v.ct, v.op});
    respond_core(v);
    drain(v);
    chk($sformatf("j%0d_held_operands", vi), {60'h0, core_const_time, core_op_code}, {60'h0, v.ct, v.op});
    chk($sformatf("j%0d_start_pulses", vi), 64'(start_cnt - s0), 64'd1);
  endtask

  task automatic reset_mid_job();
    int s0;
    s0 = start_cnt;
    send_word({28'h0, 1'b1, 3'd3}, 1'b0);
    for (int k = 0; k < 20; k++) send_word(32'hFFFF_FFFF, 1'b0);
    chk("mid_busy_before_rst", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", {59'h0, busy, ifc.in_ready, core_start, core_const_time, ifc.out_valid}, 64'h0);
    chk_w("mid_rst_core_a", {5'h0, core_a}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_rst", {62'h0, ifc.in_ready, busy}, 64'h2);
    chk("mid_no_start", 64'(start_cnt - s0), 64'd0);
  endtask

  initial begin
    logic [1283:0] t;
    vecs[0] = '{op: 3'd1, ct: 1'b0, a: 1279'd48, b: 1279'd18, cyc: 12'd7,
                bza: '1, bzb: 1284'd3, mode: M_NORMAL, gaps: 1'b0};
    t = rnd_wide(); vecs[1].a = t[1278:0];
    t = rnd_wide(); vecs[1].b = t[1278:0];
    vecs[1].op = 3'd5; vecs[1].ct = 1'b1; vecs[1].cyc = 12'hA5C;
    vecs[1].bza = rnd_wide(); vecs[1].bzb = rnd_wide();
    vecs[1].mode = M_NORMAL; vecs[1].gaps = 1'b1;
    t = rnd_wide(); vecs[2].a = t[1278:0];
    vecs[2].b = 1279'h1234_5678_9ABC;
    vecs[2].op = 3'd2; vecs[2].ct = 1'b0; vecs[2].cyc = 12'h123;
    vecs[2].bza = rnd_wide(); vecs[2].bzb = rnd_wide();
    vecs[2].mode = M_HOLD; vecs[2].gaps = 1'b0;
    t = rnd_wide(); vecs[3].a = t[1278:0];
    t = rnd_wide(); vecs[3].b = t[1278:0];
    vecs[3].op = 3'd7; vecs[3].ct = 1'b1; vecs[3].cyc = 12'hFFF;
    vecs[3].bza = rnd_wide(); vecs[3].bzb = rnd_wide();
    vecs[3].mode = M_TIMEOUT; vecs[3].gaps = 1'b1;

    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;
    core_done = 1'b0; core_cycle_count = '0; core_bezout_a = '0; core_bezout_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {57'h0, core_op_code, ifc.in_ready, ifc.out_valid, busy, core_start},
        64'h0);
    chk("rst_out_data", {32'h0, ifc.out_data}, 64'h0);
    chk("rst_ct", {63'h0, core_const_time}, 64'h0);
    chk_w("rst_core_a", {5'h0, core_a}, '0);
    chk_w("rst_core_b", {5'h0, core_b}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {62'h0, ifc.in_ready, busy}, 64'h2);

    run_job(0);
    reset_mid_job();
    run_job(1);
    run_job(2);
    run_job(3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
